// File: rtl/cpack_pkg.sv
// C-Pack token encoding shared by the compressor and decompressor matching stages.
// Both sides must agree on prefixes and dictionary geometry to stay bit-identical.
package cpack_pkg;

  localparam int DICT_ENTRY = 16;
  localparam int DICT_WORD  = 32;
  localparam int WORD       = 32;
  localparam int CODE_W     = 34;

  localparam logic [1:0] CODE_ZZZZ = 2'b00;
  localparam logic [1:0] CODE_XXXX = 2'b01;
  localparam logic [1:0] CODE_MMMM = 2'b10;
  localparam logic [1:0] CODE_EXT  = 2'b11;

  localparam logic [1:0] SUB_MMXX = 2'b00;
  localparam logic [1:0] SUB_ZZZX = 2'b01;
  localparam logic [1:0] SUB_MMMX = 2'b10;
  localparam logic [1:0] SUB_ILL  = 2'b11;

  typedef enum logic [2:0] {
    TK_ZZZZ,
    TK_XXXX,
    TK_MMMM,
    TK_MMXX,
    TK_ZZZX,
    TK_MMMX,
    TK_ILL
  } token_kind_e;

  function automatic token_kind_e token_kind(input logic [CODE_W-1:0] t);
    token_kind_e k;
    k = TK_ILL;
    case (t[33:32])
      CODE_ZZZZ: k = TK_ZZZZ;
      CODE_XXXX: k = TK_XXXX;
      CODE_MMMM: k = TK_MMMM;
      default: begin
        case (t[31:30])
          SUB_MMXX: k = TK_MMXX;
          SUB_ZZZX: k = TK_ZZZX;
          SUB_MMMX: k = TK_MMMX;
          default:  k = TK_ILL;
        endcase
      end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/token_decoder.sv
// Reconstructs one 32-bit word from a left-aligned C-Pack token against a
// dictionary view; also reports whether the word enters the dictionary.
module token_decoder
  import cpack_pkg::*;
(
  input  logic [CODE_W-1:0]               i_code,
  input  logic [DICT_ENTRY*DICT_WORD-1:0] i_dict,
  output logic [WORD-1:0]                 o_word,
  output logic                            o_push,
  output logic                            o_illegal
);

  token_kind_e          kind;
  logic [3:0]           idx;
  logic [DICT_WORD-1:0] entry;

  always_comb begin
    kind = token_kind(i_code);
    // full matches carry the index right after the 2-bit prefix, partials after the 4-bit one
    idx  = (kind == TK_MMMM) ? i_code[31:28] : i_code[29:26];
  end

  assign entry = i_dict[idx*DICT_WORD +: DICT_WORD];

  always_comb begin
    o_word    = '0;
    o_push    = 1'b0;
    o_illegal = 1'b0;
    case (kind)
      TK_ZZZZ: o_word = '0;
      TK_XXXX: begin
        o_word = i_code[31:0];
        o_push = 1'b1;
      end
      TK_MMMM: o_word = entry;
      TK_MMXX: begin
        o_word = {entry[31:16], i_code[25:10]};
        o_push = 1'b1;
      end
      TK_ZZZX: o_word = {24'b0, i_code[29:22]};
      TK_MMMX: begin
        o_word = {entry[31:8], i_code[25:18]};
        o_push = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decompression_matching_stage.sv
// Decodes one C-Pack token pair per cycle into two words and maintains the
// 16-entry shift-FIFO dictionary in lockstep with the compressor.
module decompression_matching_stage #(
  parameter int WIDTH      = 64,
  parameter int DICT_ENTRY = 16,
  parameter int DICT_WORD  = 32,
  parameter int WORD       = 32,
  parameter int CODE_W     = 34
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [CODE_W-1:0]               i_code1,
  input  logic [CODE_W-1:0]               i_code2,
  input  logic                            i_last,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [WIDTH-1:0]                o_word,
  output logic                            o_last,
  output logic                            o_error,
  output logic [DICT_ENTRY*DICT_WORD-1:0] o_dictionary_data
);

  localparam int DW = DICT_ENTRY * DICT_WORD;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             last_q, last_d;
  logic             error_q, error_d;
  logic [DW-1:0]    dict_q, dict_d;

  logic [WORD-1:0]  w1, w2;
  logic             push1, push2, ill1, ill2;
  logic [DW-1:0]    dict_view2;
  logic             accept;

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  token_decoder u_dec1 (
    .i_code    (i_code1),
    .i_dict    (dict_q),
    .o_word    (w1),
    .o_push    (push1),
    .o_illegal (ill1)
  );

  // second token sees the dictionary as if the first word had already been pushed
  assign dict_view2 = push1 ? {dict_q[DW-DICT_WORD-1:0], w1} : dict_q;

  token_decoder u_dec2 (
    .i_code    (i_code2),
    .i_dict    (dict_view2),
    .o_word    (w2),
    .o_push    (push2),
    .o_illegal (ill2)
  );

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    last_d  = last_q;
    error_d = error_q;
    dict_d  = dict_q;
    if (accept) begin
      valid_d = 1'b1;
      word_d  = {w2, w1};
      last_d  = i_last;
      error_d = ill1 || ill2;
      case ({push1, push2})
        2'b11:   dict_d = {dict_q[DW-2*DICT_WORD-1:0], w1, w2};
        2'b10:   dict_d = {dict_q[DW-DICT_WORD-1:0], w1};
        2'b01:   dict_d = {dict_q[DW-DICT_WORD-1:0], w2};
        default: dict_d = dict_q;
      endcase
      // block boundary wipes the dictionary even if this pair pushed
      if (i_last) dict_d = '0;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      dict_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      last_q  <= last_d;
      error_q <= error_d;
      dict_q  <= dict_d;
    end
  end

  assign o_valid           = valid_q;
  assign o_word            = word_q;
  assign o_last            = last_q;
  assign o_error           = error_q;
  assign o_dictionary_data = dict_q;

endmodule

// File: tb/tb_decompression_matching_stage.sv
// Directed and randomized token pairs against a sequential push/lookup model.
module tb_decompression_matching_stage;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [33:0]  i_code1 = '0;
  logic [33:0]  i_code2 = '0;
  logic         i_last = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [63:0]  o_word;
  logic         o_last;
  logic         o_error;
  logic [511:0] o_dictionary_data;

  decompression_matching_stage dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_code1           (i_code1),
    .i_code2           (i_code2),
    .i_last            (i_last),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_word            (o_word),
    .o_last            (o_last),
    .o_error           (o_error),
    .o_dictionary_data (o_dictionary_data)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: index 0 is the newest dictionary entry
  logic [31:0] mdict [16];
  logic        exp_valid, exp_last, exp_err;
  logic [63:0] exp_word;

  function automatic logic [511:0] pack_dict();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = mdict[k];
    return v;
  endfunction

  task automatic mpush(inout logic [31:0] d [16], input logic [31:0] w);
    for (int k = 15; k > 0; k--) d[k] = d[k-1];
    d[0] = w;
  endtask

  task automatic mdecode(input logic [33:0] t, input logic [31:0] d [16],
                         output logic [31:0] w, output logic p, output logic il);
    logic [3:0] pre;
    pre = t[33:30];
    w = 32'h0; p = 1'b0; il = 1'b0;
    if (t[33:32] == 2'b00)      w = 32'h0;
    else if (t[33:32] == 2'b01) begin w = t[31:0]; p = 1'b1; end
    else if (t[33:32] == 2'b10) w = d[t[31:28]];
    else if (pre == 4'b1100) begin w = {d[t[29:26]][31:16], t[25:10]}; p = 1'b1; end
    else if (pre == 4'b1101) w = {24'h0, t[29:22]};
    else if (pre == 4'b1110) begin w = {d[t[29:26]][31:8], t[25:18]}; p = 1'b1; end
    else il = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mdict[k] = 32'h0;
    exp_valid = 1'b0; exp_last = 1'b0; exp_err = 1'b0; exp_word = 64'h0;
  endtask

  task automatic model_accept(input logic [33:0] c1, input logic [33:0] c2, input logic last);
    logic [31:0] w1, w2;
    logic p1, p2, il1, il2;
    logic [31:0] work [16];
    work = mdict;
    mdecode(c1, work, w1, p1, il1);
    if (p1) mpush(work, w1);
    mdecode(c2, work, w2, p2, il2);
    if (p2) mpush(work, w2);
    if (last) for (int k = 0; k < 16; k++) work[k] = 32'h0;
    mdict     = work;
    exp_valid = 1'b1;
    exp_word  = {w2, w1};
    exp_last  = last;
    exp_err   = il1 | il2;
  endtask

  // one cycle, entered and left at a negedge
  task automatic step(input logic v, input logic [33:0] c1, input logic [33:0] c2,
                      input logic last, input logic rdy);
    logic acc;
    i_valid = v; i_code1 = c1; i_code2 = c2; i_last = last; i_ready = rdy;
    #1;
    chk("o_ready", 512'(o_ready), 512'(!exp_valid || rdy));
    acc = v && (!exp_valid || rdy);
    @(posedge i_clk);
    if (acc) model_accept(c1, c2, last);
    else if (rdy) exp_valid = 1'b0;
    #1;
    chk("o_valid", 512'(o_valid), 512'(exp_valid));
    chk("o_word",  512'(o_word),  512'(exp_word));
    chk("o_last",  512'(o_last),  512'(exp_last));
    chk("o_error", 512'(o_error), 512'(exp_err));
    chk("dict",    o_dictionary_data, pack_dict());
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  function automatic logic [33:0] rand_tok();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  logic [63:0] held_word;
  logic [31:0] prev_e0;

  initial begin
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 512'(o_valid), 512'(0));
    chk("rst_word",  512'(o_word),  512'(0));
    chk("rst_last",  512'(o_last),  512'(0));
    chk("rst_error", 512'(o_error), 512'(0));
    chk("rst_dict",  o_dictionary_data, 512'(0));
    i_reset = 1'b1;
    @(negedge i_clk);

    // xxxx then mmmm idx0 forwarded from the first word
    step(1'b1, {2'b01, 32'hDEADBEEF}, {2'b10, 32'h0}, 1'b0, 1'b1);
    chk("t1_word", 512'(o_word), 512'(64'hDEADBEEF_DEADBEEF));
    chk("t1_e0",   512'(o_dictionary_data[31:0]),  512'(32'hDEADBEEF));
    chk("t1_e1",   512'(o_dictionary_data[63:32]), 512'(32'h0));

    // mmxx idx0 + mmmx idx1
    step(1'b1, {4'b1100, 4'h0, 16'h1234, 10'h0}, {4'b1110, 4'h1, 8'h55, 18'h0}, 1'b0, 1'b1);
    chk("t2_word", 512'(o_word), 512'(64'hDEADBE55_DEAD1234));
    chk("t2_e012", 512'(o_dictionary_data[95:0]), 512'({32'hDEADBEEF, 32'hDEAD1234, 32'hDEADBE55}));

    // zzzz + zzzx
    step(1'b1, 34'h0, {4'b1101, 8'hA5, 22'h0}, 1'b0, 1'b1);
    chk("t3_word", 512'(o_word), 512'(64'h000000A5_00000000));

    // 17 pushes, oldest falls off
    for (int k = 1; k <= 17; k++)
      step(1'b1, {2'b01, 32'hA0000000 + 32'(k)}, 34'h0, 1'b0, 1'b1);
    chk("t4_e0",  512'(o_dictionary_data[31:0]),    512'(32'hA0000011));
    chk("t4_e15", 512'(o_dictionary_data[511:480]), 512'(32'hA0000002));

    // illegal second token
    prev_e0 = mdict[0];
    step(1'b1, {2'b01, 32'hCAFEF00D}, {4'b1111, 30'h0}, 1'b0, 1'b1);
    chk("t5_err", 512'(o_error), 512'(1));
    chk("t5_w2",  512'(o_word[63:32]), 512'(0));
    chk("t5_e01", 512'(o_dictionary_data[63:0]), 512'({prev_e0, 32'hCAFEF00D}));

    // back-pressure for three cycles
    step(1'b1, {2'b01, 32'h13579BDF}, {2'b01, 32'h2468ACE0}, 1'b0, 1'b1);
    held_word = o_word;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, rand_tok(), rand_tok(), 1'b0, 1'b0);
      chk("t6_hold", 512'(o_word), 512'(held_word));
    end

    // block end clears the dictionary
    step(1'b1, {2'b01, 32'h11112222}, {2'b01, 32'h33334444}, 1'b1, 1'b1);
    chk("t7_last", 512'(o_last), 512'(1));
    chk("t7_dict", o_dictionary_data, 512'(0));

    // asynchronous reset mid-stream
    step(1'b1, {2'b01, 32'h55556666}, 34'h0, 1'b0, 1'b1);
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    chk("t8_valid", 512'(o_valid), 512'(0));
    chk("t8_dict",  o_dictionary_data, 512'(0));
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);

    // random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, rand_tok(), rand_tok(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decompression_matching_stage.md
Name: decompression_matching_stage

Overview:
Decoder-side counterpart of the compression matching stage. Each cycle it accepts a pair of C-Pack tokens (first word, second word) and reconstructs the two 32-bit words. It resolves dictionary references against a 16-entry FIFO dictionary and updates that dictionary with exactly the push rule the compressor uses, so both dictionaries stay bit-identical. It sits between the token unpacker (upstream) and the decompressed-data output buffer (downstream).

Parameters:
WIDTH, 64, width of the reconstructed word pair
DICT_ENTRY, 16, number of dictionary entries
DICT_WORD, 32, dictionary entry width
WORD, 32, width of one uncompressed word
CODE_W, 34, width of one left-aligned token slot

Ports:
i_clk  input  1  clock
i_reset  input  1  reset, asynchronous, active-low
i_valid  input  1  token pair valid
o_ready  output  1  stage can accept a token pair
i_code1  input  CODE_W  first-word token, left-aligned (prefix at MSB)
i_code2  input  CODE_W  second-word token, left-aligned
i_last  input  1  pair is the last of a compression block
o_valid  output  1  reconstructed pair valid
i_ready  input  1  downstream accepts the pair
o_word  output  WIDTH  {second word, first word}
o_last  output  1  registered copy of i_last
o_error  output  1  illegal code in the pair
o_dictionary_data  output  DICT_ENTRY*DICT_WORD  {e15..e0}; entry i at [32i+31:32i]

Behaviour:
- Reset (i_reset=0, async): o_valid=0, o_word=0, o_last=0, o_error=0, all dictionary entries 0.
- Handshake: o_ready = !o_valid || i_ready. A pair is accepted on a clock edge with i_valid && o_ready. The accepted pair drives o_valid=1 after that edge (1-cycle latency). o_valid falls only when it is consumed with no new pair accepted. Back-to-back pairs sustain 1 pair/cycle.
- Output holds stable while o_valid && !i_ready.
- Token decode, with t = token and b = t[33:32]:
  - 00 zzzz: word = 0.
  - 01 xxxx: word = t[31:0].
  - 10 mmmm: idx = t[31:28]; word = dict[idx].
  - 11: sub = t[31:30].
    - 00 mmxx: idx = t[29:26]; word = {dict[idx][31:16], t[25:10]}.
    - 01 zzzx: word = {24'b0, t[29:22]}.
    - 10 mmmx: idx = t[29:26]; word = {dict[idx][31:8], t[25:18]}.
    - 11: illegal; word = 0, no push, o_error=1 for that pair.
- Unused low token bits are ignored.
- Dictionary: shift FIFO, e0 is newest. Push rule: xxxx, mmxx and mmmx push their decoded word. zzzz, zzzx, mmmm and illegal tokens do not push.
- Lookup ordering:
  - The first token indexes the dictionary as it stood before the pair.
  - The second token indexes the dictionary after the first word's push. If the first word pushed, second-token idx 0 returns the first word (combinational forward) and idx k returns the old e(k-1).
- Update on accept:
  - Both push: e0<=w2, e1<=w1, e(i)<=old e(i-2).
  - One pushes: e0<=that word, e(i)<=old e(i-1).
  - Neither pushes: hold.
  - Oldest entries fall off the end.
- Block end: when the accepted pair has i_last=1, the pair decodes normally, then all entries clear to 0 at that same edge. The clear overrides the push.
- Reset mid-operation: the in-flight output is discarded and the dictionary is cleared.
- No update occurs when the pair is not accepted.

Decomposition:
- Shared package (cpack_pkg, shared with the compressor): code prefix constants (CODE_ZZZZ=2'b00, CODE_XXXX=2'b01, CODE_MMMM=2'b10, CODE_EXT=2'b11, SUB_MMXX/ZZZX/MMMX/ILL), a token-kind enum, and DICT_ENTRY/WORD constants.
- Sub-module token_decoder (combinational, instanced twice): token plus a 512-bit dictionary view in; word, push flag and illegal flag out.
- The FIFO update and the output register stay in the top level.

Test Plan:
- Reset, then pair code1=34'h1_DEADBEEF (xxxx), code2=34'h2_00000000 (mmmm idx0) -> o_word=64'hDEADBEEF_DEADBEEF, o_error=0; afterwards e0=DEADBEEF and e1=0.
- From that state, code1=mmxx idx0 low16=16'h1234, code2=mmmx idx1 byte=8'h55 -> first=DEADBEEF→DEAD1234 (mmxx), second uses e1=DEADBEEF→DEADBE55; afterwards e0=DEADBE55, e1=DEAD1234, e2=DEADBEEF.
- Pair zzzz + zzzx byte=8'hA5 -> o_word=64'h000000A5_00000000; dictionary unchanged.
- Push 17 distinct xxxx words one per pair (each paired with zzzz) -> e0 holds the 17th word, e15 holds the 2nd, and the 1st has fallen off.
- Illegal token (prefix 1111) in code2 with xxxx in code1 -> o_error=1, second word=0; only the first word is pushed.
- Hold i_ready=0 for 3 cycles with o_valid=1 -> o_ready=0, o_word stable, dictionary unchanged.
- Then send a pair with i_last=1 -> o_last=1 and all dictionary entries read 0 after the edge.
- Assert i_reset low mid-stream -> o_valid=0 immediately.
